// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, single-outstanding imem requests, and a {pc, instr}
// fetch queue drained by decode over valid/ready; redirects flush and restart fetch.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter int unsigned           FQ_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        imem_req_valid_o,
  input  logic                        imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]       imem_req_addr_o,
  input  logic                        imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0]      imem_rsp_data_i,
  output logic                        instr_valid_o,
  input  logic                        instr_ready_i,
  output logic [INSTR_WIDTH-1:0]      instr_o,
  output logic [ADDR_WIDTH-1:0]       pc_o,
  input  logic                        redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]       redirect_pc_i,
  output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]   req_pc_q, req_pc_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [INSTR_WIDTH-1:0]  fq_instr_q [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]   fq_pc_q    [FQ_DEPTH];

  logic                    req_valid_c;
  logic                    instr_valid_c;
  logic                    has_space_c;
  logic                    fq_empty_c;
  logic                    push_c;
  logic                    pop_c;
  logic                    unused_rpc_lsb_c;

  // Low two bits of the restart PC are forced to zero, so they are never consumed.
  assign unused_rpc_lsb_c = ^redirect_pc_i[1:0];

  // State, PC and queue bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; only the slot at the write pointer changes on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        fq_instr_q[i] <= '0;
        fq_pc_q[i]    <= '0;
      end
    end else if (push_c) begin
      fq_instr_q[wr_ptr_q] <= imem_rsp_data_i;
      fq_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

  // Next-state, request and queue control.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    req_valid_c   = 1'b0;
    push_c        = 1'b0;

    has_space_c   = (count_q < CNT_W'(FQ_DEPTH));
    fq_empty_c    = (count_q == '0);
    instr_valid_c = ~fq_empty_c & ~redirect_valid_i;
    pop_c         = instr_valid_c & instr_ready_i;

    case (state_q)
      S_FETCH: begin
        req_valid_c = has_space_c & ~redirect_valid_i;
        if (req_valid_c && imem_req_ready_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          push_c  = ~redirect_valid_i;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid_i) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    // Redirect overrides everything; an outstanding request not answered this cycle must be drained.
    if (redirect_valid_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
      if ((state_q != S_FETCH) && !imem_rsp_valid_i) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Outputs are forced to zero while reset is asserted.
  always_comb begin
    imem_req_valid_o = rst_n & req_valid_c;
    imem_req_addr_o  = rst_n ? pc_q : '0;
    instr_valid_o    = rst_n & instr_valid_c;
    instr_o          = (rst_n && !fq_empty_c) ? fq_instr_q[rd_ptr_q] : '0;
    pc_o             = (rst_n && !fq_empty_c) ? fq_pc_q[rd_ptr_q]    : '0;
    fq_count_o       = count_q;
  end

endmodule
